// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Conditions raw board inputs (run/valid switches, step button,
//            in[4:0] switches) for the peripheral/debug unit. Each bit goes
//            through a 2-flop synchroniser and then a stability counter. A new
//            level reaches db_out only after it has held for STABLE_CNT
//            consecutive cycles at the synchroniser output.
// Ports    : clk      - system clock (shared with the peripheral/debug unit)
//            rst_n    - asynchronous active-low reset
//            raw_in   - unsynchronised switch/button levels  [N_IN]
//            db_out   - debounced levels                     [N_IN]
//            db_rise  - one-cycle pulse on db_out 0->1       [N_IN] (optional)
//            db_fall  - one-cycle pulse on db_out 1->0       [N_IN] (optional)
//            busy     - some bit currently has a change being qualified
// Config   : define DEBOUNCE_EDGE_EN to add the registered db_rise/db_fall
//            ports. Without it, db_out and busy behave identically.
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int N_IN       = 8,
    parameter int CNT_W      = 20,
    parameter int STABLE_CNT = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] db_out,
`ifdef DEBOUNCE_EDGE_EN
    output logic [N_IN-1:0] db_rise,
    output logic [N_IN-1:0] db_fall,
`endif
    output logic            busy
);

    // Terminal count: the STABLE_CNT-th consecutive differing sample commits.
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CNT - 1);

    logic [N_IN-1:0]  r_s1;
    logic [N_IN-1:0]  r_s2;
    logic [N_IN-1:0]  r_db;
    logic [CNT_W-1:0] r_cnt [N_IN];

    logic [N_IN-1:0]  w_diff;     // synchronised level differs from output
    logic [N_IN-1:0]  w_commit;   // this edge updates db_out for the bit
    logic [N_IN-1:0]  w_cnt_nz;   // qualification in progress

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_bit
            assign w_diff[gi]   = r_s2[gi] ^ r_db[gi];
            assign w_commit[gi] = w_diff[gi] && (r_cnt[gi] == c_cnt_max);
            assign w_cnt_nz[gi] = (r_cnt[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_db <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
            for (int i = 0; i < N_IN; i++) begin
                if (!w_diff[i]) begin
                    // Any return to the current output level restarts qualification.
                    r_cnt[i] <= '0;
                end else if (w_commit[i]) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign db_out = r_db;
    assign busy   = |w_cnt_nz;

`ifdef DEBOUNCE_EDGE_EN
    logic [N_IN-1:0] r_rise;
    logic [N_IN-1:0] r_fall;

    // Registered alongside r_db so the pulse lines up with the db_out change.
    // The direction comes from the new level, so rise and fall are exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_commit & r_s2;
            r_fall <= w_commit & ~r_s2;
        end
    end

    assign db_rise = r_rise;
    assign db_fall = r_fall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed self-checking bench for input_debouncer with
//            N_IN=8, CNT_W=4, STABLE_CNT=4. Inputs change #1 after a rising
//            edge ("edge 0"); outputs are sampled #1 after later edges.
//            Edge-pulse checks are present only when DEBOUNCE_EDGE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic       clk;
    logic       rst_n;
    logic [7:0] raw_in;
    logic [7:0] db_out;
    logic       busy;
`ifdef DEBOUNCE_EDGE_EN
    logic [7:0] db_rise;
    logic [7:0] db_fall;
`endif

    int n_cmp;
    int n_bad;

    input_debouncer #(
        .N_IN       (8),
        .CNT_W      (4),
        .STABLE_CNT (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_in  (raw_in),
        .db_out  (db_out),
`ifdef DEBOUNCE_EDGE_EN
        .db_rise (db_rise),
        .db_fall (db_fall),
`endif
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef DEBOUNCE_EDGE_EN
    logic [7:0] rise_acc;
`endif

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        raw_in = 8'hFF;

        // ---- 1: reset with inputs high, then re-qualify after release ----
        tick(3);
        chk("rst_db_out", db_out, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
`ifdef DEBOUNCE_EDGE_EN
        chk("rst_rise", db_rise, 8'h00);
        chk("rst_fall", db_fall, 8'h00);
`endif
        rst_n = 1'b1;                         // edge 0
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk($sformatf("t1_db_e%0d", k), db_out, 8'h00);
            if (k == 4) chk("t1_busy_e4", {7'd0, busy}, 8'h01);
        end
        tick(1);                              // edge 6
        chk("t1_db_e6", db_out, 8'hFF);
        chk("t1_busy_e6", {7'd0, busy}, 8'h00);
`ifdef DEBOUNCE_EDGE_EN
        chk("t1_rise_e6", db_rise, 8'hFF);
        tick(1);
        chk("t1_rise_e7", db_rise, 8'h00);
`endif

        // ---- return everything to 0 ----
        raw_in = 8'h00;
        tick(5);
        chk("clr_db_e5", db_out, 8'hFF);
        tick(1);
        chk("clr_db_e6", db_out, 8'h00);
`ifdef DEBOUNCE_EDGE_EN
        chk("clr_fall_e6", db_fall, 8'hFF);
        chk("clr_rise_e6", db_rise, 8'h00);
`endif
        tick(2);

        // ---- 2: single bit rise ----
        raw_in = 8'h02;
        tick(5);
        chk("t2_db_e5", db_out, 8'h00);
`ifdef DEBOUNCE_EDGE_EN
        chk("t2_rise_e5", db_rise, 8'h00);
`endif
        tick(1);
        chk("t2_db_e6", db_out, 8'h02);
`ifdef DEBOUNCE_EDGE_EN
        chk("t2_rise_e6", db_rise, 8'h02);
`endif
        tick(1);
        chk("t2_db_e7", db_out, 8'h02);
`ifdef DEBOUNCE_EDGE_EN
        chk("t2_rise_e7", db_rise, 8'h00);
`endif

        // ---- 3: 3-cycle glitch on bit 2 is rejected ----
`ifdef DEBOUNCE_EDGE_EN
        rise_acc = 8'h00;
`endif
        raw_in = 8'h06;                       // edge 0
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 3) raw_in = 8'h02;
            if (k == 4) chk("t3_busy_e4", {7'd0, busy}, 8'h01);
            if (k == 6) chk("t3_busy_e6", {7'd0, busy}, 8'h00);
`ifdef DEBOUNCE_EDGE_EN
            rise_acc = rise_acc | db_rise;
`endif
        end
        chk("t3_db", db_out, 8'h02);
        chk("t3_busy_end", {7'd0, busy}, 8'h00);
`ifdef DEBOUNCE_EDGE_EN
        chk("t3_no_rise", rise_acc, 8'h00);
`endif

        // ---- 4: bouncing bit 0 qualifies only after the final four 1s ----
        begin
            logic [8:0] seq;
            seq = 9'b1_1110_1101;             // bit j = value applied after edge j
            for (int j = 0; j <= 8; j++) begin
                raw_in = {7'b0000001, seq[j]};
                tick(1);
                if (j == 6) chk("t4_db_e7", db_out, 8'h02);
            end
        end
        chk("t4_db_e9", db_out, 8'h02);
        tick(1);
        chk("t4_db_e10", db_out, 8'h02);
        tick(1);
        chk("t4_db_e11", db_out, 8'h03);
`ifdef DEBOUNCE_EDGE_EN
        chk("t4_rise_e11", db_rise, 8'h01);
`endif

        // ---- 5: simultaneous multi-bit change ----
        raw_in = 8'h00;
        tick(8);
        chk("t5_clear", db_out, 8'h00);
        raw_in = 8'hA5;                       // edge 0
        tick(5);
        chk("t5_db_e5", db_out, 8'h00);
        chk("t5_busy_e5", {7'd0, busy}, 8'h01);
        tick(1);
        chk("t5_db_e6", db_out, 8'hA5);
`ifdef DEBOUNCE_EDGE_EN
        chk("t5_rise_e6", db_rise, 8'hA5);
        chk("t5_fall_e6", db_fall, 8'h00);
`endif
        tick(1);
        chk("t5_db_e7", db_out, 8'hA5);
`ifdef DEBOUNCE_EDGE_EN
        chk("t5_rise_e7", db_rise, 8'h00);
`endif

        // ---- 6: reset in the middle of qualifying bit 3 ----
        raw_in = 8'hAD;                       // edge 0
        tick(4);                              // cnt[3] == 2 now
        chk("t6_busy_pre", {7'd0, busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_db", db_out, 8'h00);
        chk("t6_rst_busy", {7'd0, busy}, 8'h00);
        tick(1);
        rst_n = 1'b1;                         // edge 0 after release
        tick(3);
        chk("t6_busy_e3", {7'd0, busy}, 8'h01);
        tick(2);
        chk("t6_db_e5", db_out, 8'h00);
        tick(1);
        chk("t6_db_e6", db_out, 8'hAD);
`ifdef DEBOUNCE_EDGE_EN
        chk("t6_rise_e6", db_rise, 8'hAD);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
